// File: rtl/stage_branch_seq_if.sv
// Bundle between the sequence generator / control-pulse matrix and the
// stage/branch slice: strobes, test requests and write bus in; stage, flags and divide step out.
interface stage_branch_seq_if #(
    parameter int STAGE_W = 3,
    parameter int WL_W    = 16
) ();
    logic               t12;
    logic               inkl;
    logic               gojam;
    logic [STAGE_W-1:0] st_set;
    logic               rststg;
    logic               dvst;
    logic               tsgn;
    logic               tsgn2;
    logic               tov;
    logic               tmz;
    logic               tpzg;
    logic [WL_W-1:0]    wl;

    logic [STAGE_W-1:0] stg;
    logic               br1;
    logic               br2;
    logic               div_active;
    logic [3:0]         div_step;
    logic               divstg;

    modport master (
        output t12, inkl, gojam, st_set, rststg, dvst,
        output tsgn, tsgn2, tov, tmz, tpzg, wl,
        input  stg, br1, br2, div_active, div_step, divstg
    );

    modport slave (
        input  t12, inkl, gojam, st_set, rststg, dvst,
        input  tsgn, tsgn2, tov, tmz, tpzg, wl,
        output stg, br1, br2, div_active, div_step, divstg
    );
endinterface

// File: rtl/stage_branch_seq.sv
// Stage register with pending accumulator, prioritised branch flags and divide-step sequencer.
// state  | meaning
// S_IDLE | no divide in progress; t12 transfers pending stage bits into stg
// S_RUN  | divide running; t12 advances div_step, stg held at 0 until the last step
module stage_branch_seq #(
    parameter int STAGE_W   = 3,
    parameter int WL_W      = 16,
    parameter int DIV_STEPS = 4
) (
    input  logic              clk,
    input  logic              rst,
    stage_branch_seq_if.slave bus
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    localparam logic [3:0] LAST_STEP = 4'(DIV_STEPS);

    state_t             state_q, state_d;
    logic [STAGE_W-1:0] stg_q, stg_d;
    logic [STAGE_W-1:0] pend_q, pend_d;
    logic [3:0]         step_q, step_d;
    logic               divstg_q, divstg_d;
    logic               br1_q, br1_d;
    logic               br2_q, br2_d;

    logic [STAGE_W-1:0] pend_acc;
    logic [STAGE_W-1:0] xfer_val;
    logic               strobe;
    logic               wl_z, wl_mz, wl_s, wl_o;

    always_comb begin
        wl_z  = (bus.wl == '0);
        wl_mz = &bus.wl;
        wl_s  = bus.wl[WL_W-1];
        wl_o  = wl_s ^ bus.wl[WL_W-2];
    end

    always_comb begin
        pend_acc = pend_q | bus.st_set;
        xfer_val = bus.rststg ? '0 : pend_acc;
        strobe   = bus.t12 & ~bus.inkl;

        state_d  = state_q;
        step_d   = step_q;
        divstg_d = 1'b0;
        stg_d    = stg_q;
        pend_d   = bus.rststg ? '0 : pend_acc;

        if (strobe) begin
            case (state_q)
                S_IDLE: begin
                    if (bus.dvst) begin
                        state_d  = S_RUN;
                        step_d   = 4'd1;
                        divstg_d = 1'b1;
                        stg_d    = '0;
                    end else begin
                        stg_d  = xfer_val;
                        pend_d = '0;
                    end
                end
                S_RUN: begin
                    // Pending bits keep accumulating through the divide and land on the exit strobe.
                    if (step_q == LAST_STEP) begin
                        state_d = S_IDLE;
                        step_d  = 4'd0;
                        stg_d   = xfer_val;
                        pend_d  = '0;
                    end else begin
                        step_d   = step_q + 4'd1;
                        divstg_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (bus.gojam) begin
            state_d  = S_IDLE;
            step_d   = 4'd0;
            divstg_d = 1'b0;
            stg_d    = '0;
            pend_d   = '0;
        end
    end

    always_comb begin
        br1_d = br1_q;
        if (bus.tov)
            br1_d = wl_s;
        else if (bus.tpzg)
            br1_d = ~wl_s & ~wl_z;
        else if (bus.tsgn)
            br1_d = wl_s;

        br2_d = br2_q;
        if (bus.tov)
            br2_d = wl_o;
        else if (bus.tpzg)
            br2_d = wl_z;
        else if (bus.tsgn2)
            br2_d = wl_s;
        else if (bus.tmz)
            br2_d = wl_mz;

        if (bus.gojam) begin
            br1_d = 1'b0;
            br2_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            step_q   <= 4'd0;
            divstg_q <= 1'b0;
            stg_q    <= '0;
            pend_q   <= '0;
            br1_q    <= 1'b0;
            br2_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            divstg_q <= divstg_d;
            stg_q    <= stg_d;
            pend_q   <= pend_d;
            br1_q    <= br1_d;
            br2_q    <= br2_d;
        end
    end

    assign bus.stg        = stg_q;
    assign bus.br1        = br1_q;
    assign bus.br2        = br2_q;
    assign bus.div_active = (state_q == S_RUN);
    assign bus.div_step   = step_q;
    assign bus.divstg     = divstg_q;

endmodule

// File: tb/tb_stage_branch_seq.sv
// Vector table plus scoreboard bench for stage_branch_seq; a few hand-written
// sequences cover full-length divide and reset during a divide.
module tb_stage_branch_seq;

    localparam int STAGE_W   = 3;
    localparam int WL_W      = 16;
    localparam int DIV_STEPS = 4;

    typedef logic [10:0] ctrl_t;
    localparam ctrl_t RST    = 11'h400;
    localparam ctrl_t T12    = 11'h200;
    localparam ctrl_t INKL   = 11'h100;
    localparam ctrl_t GOJAM  = 11'h080;
    localparam ctrl_t RSTSTG = 11'h040;
    localparam ctrl_t DVST   = 11'h020;
    localparam ctrl_t TSGN   = 11'h010;
    localparam ctrl_t TSGN2  = 11'h008;
    localparam ctrl_t TOV    = 11'h004;
    localparam ctrl_t TMZ    = 11'h002;
    localparam ctrl_t TPZG   = 11'h001;
    localparam ctrl_t NONE   = 11'h000;

    typedef struct {
        ctrl_t              ctrl;
        logic [STAGE_W-1:0] st_set;
        logic [WL_W-1:0]    wl;
        logic [STAGE_W-1:0] e_stg;
        logic               e_br1;
        logic               e_br2;
        logic               e_act;
        logic [3:0]         e_step;
        logic               e_dst;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    vec_t tbl[$];
    vec_t exp_q[$];

    stage_branch_seq_if #(.STAGE_W(STAGE_W), .WL_W(WL_W)) bus ();

    stage_branch_seq #(
        .STAGE_W  (STAGE_W),
        .WL_W     (WL_W),
        .DIV_STEPS(DIV_STEPS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t v(input ctrl_t c, input logic [STAGE_W-1:0] ss,
                               input logic [WL_W-1:0] w, input logic [STAGE_W-1:0] es,
                               input logic eb1, input logic eb2, input logic ea,
                               input logic [3:0] est, input logic ed);
        vec_t r;
        r.ctrl = c; r.st_set = ss; r.wl = w; r.e_stg = es;
        r.e_br1 = eb1; r.e_br2 = eb2; r.e_act = ea; r.e_step = est; r.e_dst = ed;
        return r;
    endfunction

    task automatic drive(input vec_t x);
        rst        = x.ctrl[10];
        bus.t12    = x.ctrl[9];
        bus.inkl   = x.ctrl[8];
        bus.gojam  = x.ctrl[7];
        bus.rststg = x.ctrl[6];
        bus.dvst   = x.ctrl[5];
        bus.tsgn   = x.ctrl[4];
        bus.tsgn2  = x.ctrl[3];
        bus.tov    = x.ctrl[2];
        bus.tmz    = x.ctrl[1];
        bus.tpzg   = x.ctrl[0];
        bus.st_set = x.st_set;
        bus.wl     = x.wl;
    endtask

    task automatic check_out(input int id);
        vec_t e;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL vec %0d: scoreboard empty", id);
            return;
        end
        e = exp_q.pop_front();
        checks++;
        if (bus.stg !== e.e_stg || bus.br1 !== e.e_br1 || bus.br2 !== e.e_br2 ||
            bus.div_active !== e.e_act || bus.div_step !== e.e_step || bus.divstg !== e.e_dst) begin
            errors++;
            $display("FAIL vec %0d: got stg=%0h br1=%0b br2=%0b act=%0b step=%0d divstg=%0b, expected stg=%0h br1=%0b br2=%0b act=%0b step=%0d divstg=%0b",
                     id, bus.stg, bus.br1, bus.br2, bus.div_active, bus.div_step, bus.divstg,
                     e.e_stg, e.e_br1, e.e_br2, e.e_act, e.e_step, e.e_dst);
        end
    endtask

    task automatic apply(input vec_t x, input int id);
        @(negedge clk);
        drive(x);
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        check_out(id);
    endtask

    task automatic check_val(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    initial begin
        int n;
        int pulses;
        int budget;

        checks = 0;
        errors = 0;
        drive(v(RST, '0, '0, '0, 0, 0, 0, 4'd0, 0));

        //         ctrl                      st_set  wl         stg     br1 br2 act step dst
        tbl.push_back(v(RST,                  3'b000, 16'h0000, 3'b000, 0, 0, 0, 4'd0, 0));
        tbl.push_back(v(NONE,                 3'b000, 16'h0000, 3'b000, 0, 0, 0, 4'd0, 0));
        tbl.push_back(v(NONE,                 3'b001, 16'h0000, 3'b000, 0, 0, 0, 4'd0, 0));
        tbl.push_back(v(NONE,                 3'b010, 16'h0000, 3'b000, 0, 0, 0, 4'd0, 0));
        tbl.push_back(v(T12,                  3'b000, 16'h0000, 3'b011, 0, 0, 0, 4'd0, 0));
        tbl.push_back(v(T12,                  3'b000, 16'h0000, 3'b000, 0, 0, 0, 4'd0, 0));
        tbl.push_back(v(NONE,                 3'b100, 16'h0000, 3'b000, 0, 0, 0, 4'd0, 0));
        tbl.push_back(v(T12|INKL,             3'b000, 16'h0000, 3'b000, 0, 0, 0, 4'd0, 0));
        tbl.push_back(v(T12,                  3'b000, 16'h0000, 3'b100, 0, 0, 0, 4'd0, 0));
        tbl.push_back(v(NONE,                 3'b100, 16'h0000, 3'b100, 0, 0, 0, 4'd0, 0));
        tbl.push_back(v(T12|RSTSTG,           3'b000, 16'h0000, 3'b000, 0, 0, 0, 4'd0, 0));
        tbl.push_back(v(T12,                  3'b010, 16'h0000, 3'b010, 0, 0, 0, 4'd0, 0));
        tbl.push_back(v(NONE,                 3'b001, 16'h0000, 3'b010, 0, 0, 0, 4'd0, 0));
        tbl.push_back(v(NONE,                 3'b000, 16'h0000, 3'b010, 0, 0, 0, 4'd0, 0));
        tbl.push_back(v(T12,                  3'b000, 16'h0000, 3'b001, 0, 0, 0, 4'd0, 0));
        tbl.push_back(v(RSTSTG,               3'b100, 16'h0000, 3'b001, 0, 0, 0, 4'd0, 0));
        tbl.push_back(v(T12,                  3'b000, 16'h0000, 3'b000, 0, 0, 0, 4'd0, 0));
        // Branch tests and priority among simultaneous requests
        tbl.push_back(v(TOV,                  3'b000, 16'h4000, 3'b000, 0, 1, 0, 4'd0, 0));
        tbl.push_back(v(TOV,                  3'b000, 16'h8000, 3'b000, 1, 1, 0, 4'd0, 0));
        tbl.push_back(v(TPZG,                 3'b000, 16'h0000, 3'b000, 0, 1, 0, 4'd0, 0));
        tbl.push_back(v(TSGN,                 3'b000, 16'h8000, 3'b000, 1, 1, 0, 4'd0, 0));
        tbl.push_back(v(TSGN2,                3'b000, 16'h0000, 3'b000, 1, 0, 0, 4'd0, 0));
        tbl.push_back(v(TMZ,                  3'b000, 16'hFFFF, 3'b000, 1, 1, 0, 4'd0, 0));
        tbl.push_back(v(TMZ,                  3'b000, 16'hFFFE, 3'b000, 1, 0, 0, 4'd0, 0));
        tbl.push_back(v(TOV|TSGN,             3'b000, 16'h0000, 3'b000, 0, 0, 0, 4'd0, 0));
        tbl.push_back(v(TPZG,                 3'b000, 16'h0005, 3'b000, 1, 0, 0, 4'd0, 0));
        tbl.push_back(v(TPZG|TSGN|TSGN2|TMZ,  3'b000, 16'hFFFF, 3'b000, 0, 0, 0, 4'd0, 0));
        tbl.push_back(v(TSGN2|TMZ,            3'b000, 16'h8000, 3'b000, 0, 1, 0, 4'd0, 0));
        tbl.push_back(v(T12,                  3'b000, 16'h0000, 3'b000, 0, 1, 0, 4'd0, 0));
        // Divide sequence with pending bits collected across it
        tbl.push_back(v(NONE,                 3'b010, 16'h0000, 3'b000, 0, 1, 0, 4'd0, 0));
        tbl.push_back(v(T12|DVST,             3'b001, 16'h0000, 3'b000, 0, 1, 1, 4'd1, 1));
        tbl.push_back(v(NONE,                 3'b000, 16'h0000, 3'b000, 0, 1, 1, 4'd1, 0));
        tbl.push_back(v(T12,                  3'b000, 16'h0000, 3'b000, 0, 1, 1, 4'd2, 1));
        tbl.push_back(v(T12|INKL,             3'b000, 16'h0000, 3'b000, 0, 1, 1, 4'd2, 0));
        tbl.push_back(v(T12|DVST,             3'b000, 16'h0000, 3'b000, 0, 1, 1, 4'd3, 1));
        tbl.push_back(v(T12,                  3'b100, 16'h0000, 3'b000, 0, 1, 1, 4'd4, 1));
        tbl.push_back(v(NONE,                 3'b000, 16'h0000, 3'b000, 0, 1, 1, 4'd4, 0));
        tbl.push_back(v(T12,                  3'b000, 16'h0000, 3'b111, 0, 1, 0, 4'd0, 0));
        tbl.push_back(v(T12,                  3'b000, 16'h0000, 3'b000, 0, 1, 0, 4'd0, 0));
        tbl.push_back(v(T12|DVST,             3'b000, 16'h0000, 3'b000, 0, 1, 1, 4'd1, 1));
        tbl.push_back(v(T12,                  3'b000, 16'h0000, 3'b000, 0, 1, 1, 4'd2, 1));
        tbl.push_back(v(GOJAM|T12|TOV,        3'b000, 16'h8000, 3'b000, 0, 0, 0, 4'd0, 0));
        tbl.push_back(v(NONE,                 3'b000, 16'h0000, 3'b000, 0, 0, 0, 4'd0, 0));
        tbl.push_back(v(T12|TOV,              3'b101, 16'h8000, 3'b101, 1, 1, 0, 4'd0, 0));
        tbl.push_back(v(GOJAM,                3'b010, 16'h0000, 3'b000, 0, 0, 0, 4'd0, 0));
        tbl.push_back(v(T12,                  3'b000, 16'h0000, 3'b000, 0, 0, 0, 4'd0, 0));
        tbl.push_back(v(T12|DVST|INKL,        3'b000, 16'h0000, 3'b000, 0, 0, 0, 4'd0, 0));
        tbl.push_back(v(T12,                  3'b000, 16'h0000, 3'b000, 0, 0, 0, 4'd0, 0));

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], i);

        // Full-length divide with t12 held high: one step per cycle until the exit strobe.
        apply(v(T12|DVST, 3'b000, 16'h0000, 3'b000, 0, 0, 1, 4'd1, 1), 100);
        pulses = 1;
        n      = 0;
        budget = 4 * DIV_STEPS + 8;
        while (bus.div_active === 1'b1 && n < budget) begin
            @(negedge clk);
            drive(v(T12, '0, '0, '0, 0, 0, 0, 4'd0, 0));
            @(posedge clk);
            #1;
            n++;
            if (bus.divstg === 1'b1) pulses++;
        end
        check_val("div_len_cycles", n, DIV_STEPS);
        check_val("div_pulses", pulses, DIV_STEPS);
        check_val("div_step_after", int'(bus.div_step), 0);

        // Synchronous reset mid-divide drops straight to idle and clears pending bits.
        apply(v(T12|DVST, 3'b000, 16'h0000, 3'b000, 0, 0, 1, 4'd1, 1), 200);
        apply(v(NONE,     3'b011, 16'h0000, 3'b000, 0, 0, 1, 4'd1, 0), 201);
        apply(v(T12|RST,  3'b000, 16'h0000, 3'b000, 0, 0, 0, 4'd0, 0), 202);
        apply(v(T12,      3'b000, 16'h0000, 3'b000, 0, 0, 0, 4'd0, 0), 203);
        apply(v(NONE,     3'b000, 16'h0000, 3'b000, 0, 0, 0, 4'd0, 0), 204);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
